// File: rtl/dev_bus_pkg.sv
// dev_bus_pkg
//   Shared definitions for the device-bus arbiter: FSM state encoding,
//   the position of the device index inside a master address, and the
//   default read data returned for an unmapped device.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned DEV_IDX_MSB = 11;
  localparam int unsigned DEV_IDX_LSB = 8;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hdead_beef;

endpackage

// File: rtl/dev_bus_rr_arb.sv
// dev_bus_rr_arb
//   Two-requester round-robin grant. With a single requester the grant goes
//   to it; with both requesting, the one not granted last wins. The last
//   grant is only remembered when the grant is actually consumed (take_i).
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset (last grant -> m1, so m0
//                wins the first tie)
//   req_i   in   [1:0] requests, bit 0 = m0, bit 1 = m1
//   take_i  in   grant is consumed this cycle
//   gnt_o   out  granted master (0 = m0, 1 = m1), combinational
module dev_bus_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o
);

  logic last_gnt_q;
  logic last_gnt_d;

  always_comb begin
    gnt_o      = req_i[1];
    if (req_i == 2'b11) begin
      gnt_o = ~last_gnt_q;
    end
    last_gnt_d = last_gnt_q;
    if (take_i) begin
      last_gnt_d = gnt_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter
//   Shares a single-cycle device bus between two masters (m0 = CPU data
//   port, m1 = debug master). Each transaction runs IDLE -> ACCESS -> DONE:
//   the request is granted and latched in IDLE, the device bus is driven in
//   ACCESS, and the granted master sees a one-cycle ack in DONE.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_req/we/addr/wdata     master X request; held stable until mX_ack
//   mX_ack/rdata/err         one-cycle completion, read data (held until
//                            the next ack), unmapped-device flag
//   dev_addr, dev_in         broadcast register address / write data
//   dev_we, dev_sel          one-hot write enable / select (ACCESS only)
//   dev_out_bus              device read data, device i at [32*i +: 32]
module dev_bus_arbiter
  import dev_bus_pkg::*;
#(
  parameter int unsigned NDEV     = 4,
  parameter logic [31:0] BAD_DATA = BAD_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [11:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [11:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic [7:0]        dev_addr,
  output logic [31:0]       dev_in,
  output logic [NDEV-1:0]   dev_we,
  output logic [NDEV-1:0]   dev_sel,
  input  logic [NDEV*32-1:0] dev_out_bus
);

  state_e      state_q, state_d;
  logic        gnt_q;
  logic        we_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;

  logic            arb_gnt;
  logic            take;
  logic            in_access;
  logic [3:0]      idx;
  logic [NDEV-1:0] hit;
  logic            mapped;
  logic [31:0]     rd_mux;

  // A grant is consumed only when a request is seen while idle; requests
  // arriving in ACCESS/DONE simply wait for the next IDLE.
  assign take      = (state_q == ST_IDLE) && (m0_req || m1_req);
  assign in_access = (state_q == ST_ACCESS);

  dev_bus_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({m1_req, m0_req}),
    .take_i (take),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (take) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        gnt_q   <= arb_gnt;
        we_q    <= arb_gnt ? m1_we    : m0_we;
        addr_q  <= arb_gnt ? m1_addr  : m0_addr;
        wdata_q <= arb_gnt ? m1_wdata : m0_wdata;
      end
    end
  end

  // Device decode: an index outside 0..NDEV-1 matches no hit bit, so the
  // select/write-enable stay all-zero and the read mux falls to BAD_DATA.
  assign idx = addr_q[DEV_IDX_MSB:DEV_IDX_LSB];

  generate
    for (genvar gi = 0; gi < NDEV; gi++) begin : g_dec
      assign hit[gi]     = (idx == 4'(gi));
      assign dev_sel[gi] = in_access && hit[gi];
      assign dev_we[gi]  = in_access && we_q && hit[gi];
    end
  endgenerate

  assign mapped   = |hit;
  assign dev_addr = in_access ? addr_q[7:0] : 8'h00;
  assign dev_in   = in_access ? wdata_q     : 32'h0;

  always_comb begin
    rd_mux = BAD_DATA;
    for (int i = 0; i < NDEV; i++) begin
      if (hit[i]) rd_mux = dev_out_bus[32*i +: 32];
    end
  end

  // Response registers: loaded on the ACCESS->DONE edge so ack/err are
  // high exactly during DONE. For writes the captured data is the value
  // the device presented before the write took effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      if (in_access) begin
        if (gnt_q) begin
          m1_ack_q   <= 1'b1;
          m1_err_q   <= ~mapped;
          m1_rdata_q <= rd_mux;
        end else begin
          m0_ack_q   <= 1'b1;
          m0_err_q   <= ~mapped;
          m0_rdata_q <= rd_mux;
        end
      end
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb_dev_bus_arbiter
//   Self-checking bench for dev_bus_arbiter: directed cases followed by
//   randomized traffic from both masters. Expected responses are pushed
//   into per-master queues at issue time and popped by a monitor on ack.
module tb_dev_bus_arbiter;

  localparam int NDEV = 4;
  localparam logic [31:0] BAD = 32'hdead_beef;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req = 2'b00;
  logic [1:0]        we  = 2'b00;
  logic [11:0]       addr  [2];
  logic [31:0]       wdata [2];
  logic              m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [7:0]        dev_addr;
  logic [31:0]       dev_in;
  logic [NDEV-1:0]   dev_we, dev_sel;
  logic [NDEV*32-1:0] dev_out_bus;
  logic [1:0]        acks;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_log[$];
  int   ack_cyc[$];
  int   ack_cnt [2];
  int   sel_cycles = 0;
  int   we_cycles  = 0;
  logic [NDEV-1:0] last_sel, last_we;
  logic [7:0]      last_addr;
  logic [31:0]     last_din;

  // Environment devices: register i/r reads a fixed pattern until written.
  bit [31:0] dev_mem [NDEV][256];
  bit        dev_wr  [NDEV][256];
  // Reference model of the same register space, updated at issue time.
  logic [31:0] ref_mem [NDEV][256];

  assign acks = {m1_ack, m0_ack};

  always #5 clk = ~clk;

  dev_bus_arbiter #(.NDEV(NDEV), .BAD_DATA(BAD)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req      (req[0]),
    .m0_we       (we[0]),
    .m0_addr     (addr[0]),
    .m0_wdata    (wdata[0]),
    .m0_ack      (m0_ack),
    .m0_rdata    (m0_rdata),
    .m0_err      (m0_err),
    .m1_req      (req[1]),
    .m1_we       (we[1]),
    .m1_addr     (addr[1]),
    .m1_wdata    (wdata[1]),
    .m1_ack      (m1_ack),
    .m1_rdata    (m1_rdata),
    .m1_err      (m1_err),
    .dev_addr    (dev_addr),
    .dev_in      (dev_in),
    .dev_we      (dev_we),
    .dev_sel     (dev_sel),
    .dev_out_bus (dev_out_bus)
  );

  function automatic logic [31:0] init_val(input int d, input logic [7:0] r);
    return 32'h1234_5678 + 32'(d - 1) * 32'h1111_0000 + 32'(r) * 32'h0000_0101;
  endfunction

  always_comb begin
    for (int i = 0; i < NDEV; i++) begin
      dev_out_bus[32*i +: 32] = dev_wr[i][dev_addr] ? dev_mem[i][dev_addr]
                                                    : init_val(i, dev_addr);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NDEV; i++) begin
      if (dev_we[i]) begin
        dev_mem[i][dev_addr] <= dev_in;
        dev_wr[i][dev_addr]  <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a master is acked.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("single ack at a time", 32'(acks == 2'b11), 32'd0);
      if (m0_ack) begin
        ack_cnt[0] <= ack_cnt[0] + 1;
        ack_log.push_back(0);
        ack_cyc.push_back(cyc);
        if (q0.size() == 0) check("m0 unexpected ack", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("m0_rdata", m0_rdata, e.rdata);
          check("m0_err", 32'(m0_err), 32'(e.err));
          $display("[TB] m0 ack rdata=%h err=%0d", m0_rdata, m0_err);
        end
      end
      if (m1_ack) begin
        ack_cnt[1] <= ack_cnt[1] + 1;
        ack_log.push_back(1);
        ack_cyc.push_back(cyc);
        if (q1.size() == 0) check("m1 unexpected ack", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("m1_rdata", m1_rdata, e.rdata);
          check("m1_err", 32'(m1_err), 32'(e.err));
          $display("[TB] m1 ack rdata=%h err=%0d", m1_rdata, m1_err);
        end
      end
    end
  end

  // Bus monitor: protocol rules on every active cycle plus activity counts.
  always @(negedge clk) begin
    if (!rst && dev_sel != '0) begin
      sel_cycles <= sel_cycles + 1;
      last_sel   <= dev_sel;
      last_we    <= dev_we;
      last_addr  <= dev_addr;
      last_din   <= dev_in;
      check("dev_sel one-hot", 32'($onehot(dev_sel)), 32'd1);
    end
    if (!rst && dev_we != '0) begin
      we_cycles <= we_cycles + 1;
      check("dev_we within dev_sel", 32'(dev_we & ~dev_sel), 32'd0);
    end
  end

  // Issue one transaction from master m; call at posedge+#1. Returns at
  // posedge+#1 after the ack, leaving req high when keep is set.
  task automatic issue(input int m, input bit w, input logic [11:0] a,
                       input logic [31:0] d, input bit keep, output int lat);
    exp_t e;
    int   di;
    di = int'(a[11:8]);
    if (di < NDEV) begin
      e.rdata = ref_mem[di][a[7:0]];
      e.err   = 1'b0;
      if (w) ref_mem[di][a[7:0]] = d;
    end else begin
      e.rdata = BAD;
      e.err   = 1'b1;
    end
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    we[m] = w; addr[m] = a; wdata[m] = d; req[m] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!acks[m] && lat < 20);
    @(posedge clk); #1;
    if (!keep) req[m] = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    int lat;
    bit keep;
    bit w;
    logic [11:0] a;
    for (int k = 0; k < n; k++) begin
      a    = {4'($urandom_range(0, 5)), 7'($urandom_range(0, 127)), 1'(m)};
      w    = 1'($urandom_range(0, 1));
      keep = (k < n - 1) && ($urandom_range(0, 2) == 0);
      issue(m, w, a, $urandom, keep, lat);
      check($sformatf("m%0d wait bound", m), 32'(lat <= 6), 32'd1);
      if (!keep) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int lat, l0, l1, s0, w0, a0, a1, base;
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    for (int d = 0; d < NDEV; d++)
      for (int r = 0; r < 256; r++) ref_mem[d][r] = init_val(d, 8'(r));

    // Reset state
    #1;
    check("reset m0_ack", 32'(m0_ack), 32'd0);
    check("reset m1_ack", 32'(m1_ack), 32'd0);
    check("reset dev_sel", 32'(dev_sel), 32'd0);
    check("reset m0_rdata", m0_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Single read by m0 from device 1
    @(posedge clk); #1;
    s0 = sel_cycles; w0 = we_cycles;
    issue(0, 1'b0, 12'h100, 32'h0, 1'b0, lat);
    check("read ack latency", lat, 3);
    check("read sel cycles", sel_cycles - s0, 1);
    check("read dev_sel", 32'(last_sel), 32'b0010);
    check("read no dev_we", we_cycles - w0, 0);
    $display("[TB] single read lat=%0d", lat);

    // Single write by m1
    s0 = sel_cycles; w0 = we_cycles; a0 = ack_cnt[0]; a1 = ack_cnt[1];
    issue(1, 1'b1, 12'h2a4, 32'hcafe_f00d, 1'b0, lat);
    check("write we cycles", we_cycles - w0, 1);
    check("write dev_we", 32'(last_we), 32'b0100);
    check("write dev_addr", 32'(last_addr), 32'ha4);
    check("write dev_in", last_din, 32'hcafe_f00d);
    check("write m1 acks", ack_cnt[1] - a1, 1);
    check("write m0 acks", ack_cnt[0] - a0, 0);
    $display("[TB] single write lat=%0d", lat);

    // Unmapped device
    s0 = sel_cycles; w0 = we_cycles;
    issue(0, 1'b0, 12'h500, 32'h0, 1'b0, lat);
    check("unmapped sel cycles", sel_cycles - s0, 0);
    check("unmapped we cycles", we_cycles - w0, 0);
    $display("[TB] unmapped read lat=%0d", lat);

    // Reset during the ACCESS cycle of an m1 write
    we[1] = 1'b1; addr[1] = 12'h310; wdata[1] = 32'h5555_aaaa; req[1] = 1'b1;
    @(posedge clk); #2;
    check("midacc dev_we before rst", 32'(dev_we), 32'b1000);
    a1 = ack_cnt[1];
    rst = 1'b1; #1;
    check("midacc dev_we", 32'(dev_we), 32'd0);
    check("midacc dev_sel", 32'(dev_sel), 32'd0);
    check("midacc m0_rdata", m0_rdata, 32'd0);
    check("midacc m1_rdata", m1_rdata, 32'd0);
    check("midacc errs", 32'({m0_err, m1_err}), 32'd0);
    req[1] = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("midacc no m1_ack", ack_cnt[1] - a1, 0);
    issue(1, 1'b0, 12'h311, 32'h0, 1'b0, lat);
    check("post-reset m1 latency", lat, 3);
    $display("[TB] reset mid-access then m1 read lat=%0d", lat);

    // m0 granted last, then reset: first tie must still go to m0
    issue(0, 1'b0, 12'h020, 32'h0, 1'b0, lat);
    #2 rst = 1'b1; #4 rst = 1'b0;
    @(posedge clk); #1;
    base = ack_log.size();
    fork
      begin
        issue(0, 1'b0, 12'h002, 32'h0, 1'b1, l0);
        issue(0, 1'b1, 12'h104, 32'h0bad_f00d, 1'b0, l0);
      end
      begin
        issue(1, 1'b1, 12'h203, 32'h7777_1111, 1'b1, l1);
        issue(1, 1'b0, 12'h005, 32'h0, 1'b0, l1);
      end
    join
    check("tie ack count", ack_log.size() - base, 4);
    if (ack_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tie order %0d", k), ack_log[base+k], exp_order[k]);
        if (k > 0) check($sformatf("tie spacing %0d", k),
                         ack_cyc[base+k] - ack_cyc[base+k-1], 3);
      end
    end
    $display("[TB] tie/fairness sequence done");

    // Randomized traffic, disjoint register sets per master
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    repeat (4) @(posedge clk); #1;
    check("m0 queue drained", q0.size(), 0);
    check("m1 queue drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Shares the single-cycle device bus (dev_out/dev_in/dev_addr/we) between two masters: m0 = CPU data port, m1 = debug/testbench master.
- Decodes a 12-bit master address into a device index and an 8-bit device register address, and pulses the selected device's write enable for exactly one cycle.
- Round-robin arbitration between the masters; unmapped devices return 32'hdead_beef with an error flag.

Parameters:
- NDEV, 4, number of attached devices (1..16); device index = addr[11:8]
- BAD_DATA, 32'hdead_beef, read data returned for an unmapped device index

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- m0_req  in  1  m0 request; addr/we/wdata held stable until m0_ack
- m0_we  in  1  m0 write (1) / read (0)
- m0_addr  in  12  [11:8] device index, [7:0] device register address
- m0_wdata  in  32  m0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid from the m0_ack cycle; held until the next m0_ack
- m0_err  out  1  with m0_ack: device index >= NDEV
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: identical meaning, for m1
- dev_addr  out  8  broadcast register address
- dev_in  out  32  broadcast write data
- dev_we  out  NDEV  one-hot write enable
- dev_sel  out  NDEV  one-hot select, asserted for reads and writes
- dev_out_bus  in  NDEV*32  device read data; device i occupies bits [32*i+31:32*i]

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Transitions are IDLE->ACCESS (any req), ACCESS->DONE (always), DONE->IDLE (always). One transaction takes 3 cycles.
- IDLE:
  - Sample m0_req and m1_req.
  - If only one is high, grant it.
  - If both are high, grant the master that was not granted last (last_gnt register). last_gnt resets to 1, so m0 wins the first tie.
  - On the granting edge, latch gnt, we, addr and wdata; update last_gnt.
- ACCESS:
  - dev_addr = latched addr[7:0]; dev_in = latched wdata.
  - dev_sel[idx] = 1. dev_we[idx] = latched we.
  - If idx >= NDEV, dev_sel and dev_we stay all-zero.
  - At the ACCESS->DONE edge, capture rdata into the granted master's rdata register:
    - dev_out_bus slice idx, or BAD_DATA if idx >= NDEV.
    - For writes, this is the device's read-before-write value.
  - Set err = (idx >= NDEV).
- DONE: granted master's ack = 1 for this cycle only; its err is valid in this cycle. The other master's ack stays 0.
- Outside ACCESS: dev_addr = 0, dev_in = 0, dev_we = 0, dev_sel = 0.
- ack and err are registered: high only in DONE, 0 otherwise.
- Masters deassert req on the edge after ack. req still high in the following IDLE starts a new transaction, which is legal back-to-back use.
- A req raised or dropped while not in IDLE is ignored until the next IDLE. Requests are never cancelled.
- Reset (asynchronous, any state, including mid-ACCESS):
  - State = IDLE, last_gnt = 1.
  - m0_ack, m1_ack, m0_err, m1_err = 0.
  - m0_rdata, m1_rdata = 0.
  - All dev_* outputs = 0 immediately.
  - An interrupted write may or may not have reached the device.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, ...
- Maximum wait for a pending request: 6 cycles.

Decomposition:
- Shared package dev_bus_pkg holds:
  - state encodings ST_IDLE, ST_ACCESS, ST_DONE
  - DEV_IDX_MSB = 11, DEV_IDX_LSB = 8
  - BAD_DATA default
- One natural sub-module: dev_bus_rr_arb (2-requester round-robin grant with last_gnt register). It is instantiated once.
- Decode and read-mux stay inline.

Test Plan:
- Reset check: assert rst mid-simulation -> all acks, errs, rdata, dev_we and dev_sel are 0 with no clock edge.
- Single read: m0 reads addr 12'h100 while device 1 drives 32'h1234_5678.
  - m0_ack pulses in the 3rd cycle after req, with m0_rdata = 32'h1234_5678 and m0_err = 0.
  - dev_sel = 4'b0010 for exactly one cycle; dev_we stays 0.
- Single write: m1 writes 32'hcafe_f00d to 12'h2a4.
  - dev_we = 4'b0100, dev_addr = 8'ha4 and dev_in = 32'hcafe_f00d for exactly one cycle.
  - m1_ack pulses once; m0_ack stays 0.
- Tie and fairness: both masters hold req for 4 transactions -> grant order m0, m1, m0, m1; each ack is 3 cycles after the previous one.
- Unmapped device (NDEV=4): m0 reads 12'h5_00 -> no dev_sel or dev_we activity, m0_rdata = 32'hdead_beef, m0_err = 1 with ack.
- Reset mid-ACCESS: pulse rst during the ACCESS cycle of an m1 write.
  - dev_we drops immediately; no m1_ack is produced.
  - A subsequent m1 request completes normally.
